// File: rtl/sd_cmd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sd_cmd_arbiter
//  Purpose  : Round-robin arbiter between the software host and the data
//             master for access to the SD command master. It loads the
//             winner's argument and setting word, strobes the command master,
//             waits for it to accept (busy high) and then finish (busy low).
//             A sticky error flag is raised if the command is never accepted.
//  Revision : 1.0  initial release
// ============================================================================
module sd_cmd_arbiter #(
   parameter int unsigned TMO_W   = 16,
   parameter int unsigned TMO_MAX = 16'hFFFF
) (
   input  logic        clk,
   input  logic        rst,
   // software host requester
   input  logic        host_req_i,
   input  logic [31:0] host_arg_i,
   input  logic [15:0] host_set_i,
   output logic        host_ack_o,
   output logic        host_done_o,
   // data master requester
   input  logic        dm_req_i,
   input  logic [31:0] dm_arg_i,
   input  logic [15:0] dm_set_i,
   output logic        dm_ack_o,
   output logic        dm_done_o,
   // command master
   output logic        cmd_we_o,
   output logic [31:0] cmd_arg_o,
   output logic [15:0] cmd_set_o,
   input  logic        cmd_busy_i,
   // status
   output logic [1:0]  grant_o,
   output logic        tmo_err_o,
   input  logic        tmo_clr_i
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_ACC  = 2'd1,
      WAIT_DONE = 2'd2
   } state_t;

   // Timeout limit widened by one bit so the incremented count never wraps
   // before it is compared.
   localparam logic [TMO_W:0] TMO_LIM = (TMO_W+1)'(TMO_MAX);

   // Last-winner pointer encoding: 0 = host, 1 = data master.
   localparam logic LAST_HOST = 1'b0;
   localparam logic LAST_DM   = 1'b1;

   state_t            state_q, state_d;
   logic [TMO_W-1:0]  cnt_q, cnt_d;
   logic              last_q, last_d;
   logic              cmd_we_q, cmd_we_d;
   logic              host_ack_q, host_ack_d;
   logic              dm_ack_q, dm_ack_d;
   logic              host_done_q, host_done_d;
   logic              dm_done_q, dm_done_d;
   logic [1:0]        grant_q, grant_d;
   logic              tmo_err_q, tmo_err_d;
   logic [31:0]       cmd_arg_q, cmd_arg_d;
   logic [15:0]       cmd_set_q, cmd_set_d;

   logic [TMO_W:0]    cnt_inc;
   logic              tmo_hit;
   logic              pick_host;
   logic              pick_dm;

   // Count as it will be after this WAIT_ACC cycle; a timeout is declared on
   // the edge where that count reaches the limit.
   assign cnt_inc = {1'b0, cnt_q} + {{TMO_W{1'b0}}, 1'b1};
   assign tmo_hit = (cnt_inc >= TMO_LIM);

   // Arbitration: a lone requester wins; on a tie the side that did not win
   // the last completed command wins.
   always_comb begin
      pick_host = 1'b0;
      pick_dm   = 1'b0;
      if (host_req_i && dm_req_i) begin
         pick_host = (last_q == LAST_DM);
         pick_dm   = (last_q == LAST_HOST);
      end else begin
         pick_host = host_req_i;
         pick_dm   = dm_req_i;
      end
   end

   // State and output registers; reset returns everything to idle and hands
   // the next tie to the host.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         last_q      <= LAST_DM;
         cmd_we_q    <= 1'b0;
         host_ack_q  <= 1'b0;
         dm_ack_q    <= 1'b0;
         host_done_q <= 1'b0;
         dm_done_q   <= 1'b0;
         grant_q     <= 2'b00;
         tmo_err_q   <= 1'b0;
         cmd_arg_q   <= '0;
         cmd_set_q   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         last_q      <= last_d;
         cmd_we_q    <= cmd_we_d;
         host_ack_q  <= host_ack_d;
         dm_ack_q    <= dm_ack_d;
         host_done_q <= host_done_d;
         dm_done_q   <= dm_done_d;
         grant_q     <= grant_d;
         tmo_err_q   <= tmo_err_d;
         cmd_arg_q   <= cmd_arg_d;
         cmd_set_q   <= cmd_set_d;
      end
   end

   // Next-state and next-output logic; pulses default low, everything else
   // holds.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      last_d      = last_q;
      cmd_we_d    = 1'b0;
      host_ack_d  = 1'b0;
      dm_ack_d    = 1'b0;
      host_done_d = 1'b0;
      dm_done_d   = 1'b0;
      grant_d     = grant_q;
      tmo_err_d   = tmo_err_q & ~tmo_clr_i;
      cmd_arg_d   = cmd_arg_q;
      cmd_set_d   = cmd_set_q;

      unique case (state_q)
         IDLE: begin
            // Requests are only looked at while the command master is free.
            if (!cmd_busy_i && (pick_host || pick_dm)) begin
               cmd_we_d = 1'b1;
               cnt_d    = '0;
               state_d  = WAIT_ACC;
               if (pick_host) begin
                  cmd_arg_d  = host_arg_i;
                  cmd_set_d  = host_set_i;
                  host_ack_d = 1'b1;
                  grant_d    = 2'b01;
               end else begin
                  cmd_arg_d  = dm_arg_i;
                  cmd_set_d  = dm_set_i;
                  dm_ack_d   = 1'b1;
                  grant_d    = 2'b10;
               end
            end
         end

         WAIT_ACC: begin
            if (cmd_busy_i) begin
               cnt_d   = '0;
               state_d = WAIT_DONE;
            end else if (tmo_hit) begin
               // Never accepted: flag it (overrides a same-cycle clear) and
               // release the owner as if the command had completed.
               cnt_d       = TMO_LIM[TMO_W-1:0];
               tmo_err_d   = 1'b1;
               host_done_d = grant_q[0];
               dm_done_d   = grant_q[1];
               last_d      = grant_q[1];
               grant_d     = 2'b00;
               state_d     = IDLE;
            end else begin
               cnt_d = cnt_inc[TMO_W-1:0];
            end
         end

         WAIT_DONE: begin
            // No timeout here: a running command is allowed any length.
            if (!cmd_busy_i) begin
               host_done_d = grant_q[0];
               dm_done_d   = grant_q[1];
               last_d      = grant_q[1];
               grant_d     = 2'b00;
               state_d     = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
            grant_d = 2'b00;
         end
      endcase
   end

   assign cmd_we_o    = cmd_we_q;
   assign host_ack_o  = host_ack_q;
   assign dm_ack_o    = dm_ack_q;
   assign host_done_o = host_done_q;
   assign dm_done_o   = dm_done_q;
   assign grant_o     = grant_q;
   assign tmo_err_o   = tmo_err_q;
   assign cmd_arg_o   = cmd_arg_q;
   assign cmd_set_o   = cmd_set_q;

endmodule
`default_nettype wire

// File: tb/tb_sd_cmd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sd_cmd_arbiter
//  Purpose  : Self-checking bench for sd_cmd_arbiter (TMO_MAX = 8). A table
//             of per-cycle vectors covers a single host command, round-robin
//             ties and reset mid-command; hand-written sequences cover the
//             busy-blocked request and the accept timeout.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sd_cmd_arbiter;

   localparam logic [31:0] H_ARG = 32'h0000_1234;
   localparam logic [15:0] H_SET = 16'h181A;
   localparam logic [31:0] D_ARG = 32'hDEAD_0042;
   localparam logic [15:0] D_SET = 16'h0A5C;

   // Packed output code: {we, host_ack, dm_ack, host_done, dm_done, grant[1:0], tmo_err}
   localparam logic [7:0] O_IDLE  = 8'h00;
   localparam logic [7:0] O_HGNT  = 8'hC2;
   localparam logic [7:0] O_HHOLD = 8'h02;
   localparam logic [7:0] O_HDONE = 8'h10;
   localparam logic [7:0] O_DGNT  = 8'hA4;
   localparam logic [7:0] O_DHOLD = 8'h04;
   localparam logic [7:0] O_DDONE = 8'h08;

   logic        clk;
   logic        rst;
   logic        host_req, dm_req, cmd_busy, tmo_clr;
   logic        host_ack, host_done, dm_ack, dm_done, cmd_we, tmo_err;
   logic [31:0] cmd_arg;
   logic [15:0] cmd_set;
   logic [1:0]  grant;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        rst;
      logic        hreq;
      logic        dreq;
      logic        busy;
      logic        clr;
      logic [7:0]  exp;
      logic [31:0] exp_arg;
      logic [15:0] exp_set;
   } vec_t;

   vec_t vecs[$];

   sd_cmd_arbiter #(.TMO_W(16), .TMO_MAX(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .host_req_i  (host_req),
      .host_arg_i  (H_ARG),
      .host_set_i  (H_SET),
      .host_ack_o  (host_ack),
      .host_done_o (host_done),
      .dm_req_i    (dm_req),
      .dm_arg_i    (D_ARG),
      .dm_set_i    (D_SET),
      .dm_ack_o    (dm_ack),
      .dm_done_o   (dm_done),
      .cmd_we_o    (cmd_we),
      .cmd_arg_o   (cmd_arg),
      .cmd_set_o   (cmd_set),
      .cmd_busy_i  (cmd_busy),
      .grant_o     (grant),
      .tmo_err_o   (tmo_err),
      .tmo_clr_i   (tmo_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] outs();
      return {cmd_we, host_ack, dm_ack, host_done, dm_done, grant, tmo_err};
   endfunction

   // Apply inputs, clock once, sample 1 time unit after the edge.
   task automatic step(input logic r, input logic h, input logic d,
                       input logic b, input logic c);
      rst = r; host_req = h; dm_req = d; cmd_busy = b; tmo_clr = c;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_outs(input string name, input logic [7:0] exp);
      checks++;
      if (outs() !== exp) begin
         errors++;
         $display("FAIL %s: outputs {we,hack,dack,hdone,ddone,grant,tmo} got %b expected %b",
                  name, outs(), exp);
      end
   endtask

   task automatic chk_data(input string name, input logic [31:0] ea,
                           input logic [15:0] es);
      checks++;
      if (cmd_arg !== ea || cmd_set !== es) begin
         errors++;
         $display("FAIL %s: cmd_arg/cmd_set got %h/%h expected %h/%h",
                  name, cmd_arg, cmd_set, ea, es);
      end
   endtask

   initial begin
      rst = 1'b1; host_req = 1'b0; dm_req = 1'b0; cmd_busy = 1'b0; tmo_clr = 1'b0;

      //              rst  hreq dreq busy clr  expected  arg    set
      // single host command, busy 2 cycles after we, low 5 cycles later
      vecs.push_back('{1'b1,1'b0,1'b0,1'b0,1'b0, O_IDLE,  32'h0, 16'h0});
      vecs.push_back('{1'b0,1'b1,1'b0,1'b0,1'b0, O_HGNT,  H_ARG, H_SET});
      vecs.push_back('{1'b0,1'b0,1'b0,1'b0,1'b0, O_HHOLD, H_ARG, H_SET});
      for (int i = 0; i < 5; i++)
         vecs.push_back('{1'b0,1'b0,1'b0,1'b1,1'b0, O_HHOLD, H_ARG, H_SET});
      vecs.push_back('{1'b0,1'b0,1'b0,1'b0,1'b0, O_HDONE, H_ARG, H_SET});
      vecs.push_back('{1'b0,1'b0,1'b0,1'b0,1'b0, O_IDLE,  H_ARG, H_SET});
      // round-robin ties after reset: host, dm, host
      vecs.push_back('{1'b1,1'b0,1'b0,1'b0,1'b0, O_IDLE,  32'h0, 16'h0});
      vecs.push_back('{1'b0,1'b1,1'b1,1'b0,1'b0, O_HGNT,  H_ARG, H_SET});
      vecs.push_back('{1'b0,1'b1,1'b1,1'b1,1'b0, O_HHOLD, H_ARG, H_SET});
      vecs.push_back('{1'b0,1'b1,1'b1,1'b0,1'b0, O_HDONE, H_ARG, H_SET});
      vecs.push_back('{1'b0,1'b1,1'b1,1'b0,1'b0, O_DGNT,  D_ARG, D_SET});
      vecs.push_back('{1'b0,1'b1,1'b1,1'b1,1'b0, O_DHOLD, D_ARG, D_SET});
      vecs.push_back('{1'b0,1'b1,1'b1,1'b0,1'b0, O_DDONE, D_ARG, D_SET});
      vecs.push_back('{1'b0,1'b1,1'b1,1'b0,1'b0, O_HGNT,  H_ARG, H_SET});
      vecs.push_back('{1'b0,1'b0,1'b0,1'b1,1'b0, O_HHOLD, H_ARG, H_SET});
      // reset while in WAIT_DONE: no done, all clear, next tie goes to host
      vecs.push_back('{1'b1,1'b0,1'b0,1'b1,1'b0, O_IDLE,  32'h0, 16'h0});
      vecs.push_back('{1'b0,1'b1,1'b1,1'b0,1'b0, O_HGNT,  H_ARG, H_SET});
      vecs.push_back('{1'b0,1'b0,1'b0,1'b1,1'b0, O_HHOLD, H_ARG, H_SET});
      vecs.push_back('{1'b0,1'b0,1'b0,1'b0,1'b0, O_HDONE, H_ARG, H_SET});
      vecs.push_back('{1'b0,1'b0,1'b0,1'b0,1'b0, O_IDLE,  H_ARG, H_SET});

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].rst, vecs[i].hreq, vecs[i].dreq, vecs[i].busy, vecs[i].clr);
         chk_outs($sformatf("vec%0d", i), vecs[i].exp);
         chk_data($sformatf("vec%0d", i), vecs[i].exp_arg, vecs[i].exp_set);
      end

      // Busy blocks arbitration: dm requests for 10 cycles with busy high.
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
         chk_outs($sformatf("busy_block%0d", i), O_IDLE);
      end
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk_outs("grant_after_busy", O_DGNT);
      chk_data("grant_after_busy", D_ARG, D_SET);

      // Accept timeout: 7 quiet WAIT_ACC cycles, timeout on the 8th with a
      // simultaneous clear that must lose.
      for (int k = 1; k < 8; k++) begin
         step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         chk_outs($sformatf("wait_acc%0d", k), O_DHOLD);
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk_outs("timeout", 8'h09);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk_outs("tmo_sticky", 8'h01);

      // Timeout moved the pointer to dm, so a tie now goes to the host.
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      chk_outs("tie_after_tmo", 8'hC3);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      chk_outs("tmo_clear", O_HHOLD);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk_outs("final_done", O_HDONE);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
